// File: rtl/wide_read_burst_mem_if.sv
// ---------------------------------------------------------------------------
// wide_read_burst_mem_if
//   Bundles the byte write port and the wide burst read port of
//   wide_read_burst_mem.
//   master : producer/consumer side (drives writes, burst requests, rd_ready)
//   slave  : memory side (drives rd_busy, rd_valid, rd_data, rd_last)
//   Signals:
//     we, wa[AW_WORD+1:0], wd[7:0]       byte write
//     rd_start, rd_addr, rd_len          burst request (len = words - 1)
//     rd_busy                            burst in progress
//     rd_valid, rd_ready                 read word handshake
//     rd_data[31:0], rd_last             read word, final-word flag
// ---------------------------------------------------------------------------
interface wide_read_burst_mem_if #(
    parameter int AW_WORD = 6
) ();
    logic               we;
    logic [AW_WORD+1:0] wa;
    logic [7:0]         wd;
    logic               rd_start;
    logic [AW_WORD-1:0] rd_addr;
    logic [AW_WORD-1:0] rd_len;
    logic               rd_busy;
    logic               rd_valid;
    logic               rd_ready;
    logic [31:0]        rd_data;
    logic               rd_last;

    modport master (
        output we, wa, wd, rd_start, rd_addr, rd_len, rd_ready,
        input  rd_busy, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  we, wa, wd, rd_start, rd_addr, rd_len, rd_ready,
        output rd_busy, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/wide_read_burst_mem.sv
// ---------------------------------------------------------------------------
// wide_read_burst_mem
//   Byte-addressed (4 * 2**AW_WORD) x 8 memory with an 8-bit write port and a
//   32-bit little-endian burst read port (lane k = mem[{word,k}]).
//   Ports:
//     clk    in  single clock, rising edge
//     rst_n  in  asynchronous active-low reset (control and rd_data only;
//                the memory array keeps its contents)
//     bus    wide_read_burst_mem_if.slave (write port + burst read port)
//   Optional feature:
//     WIDE_READ_BYPASS_EN  when defined, a write landing on the same edge as
//                          the fetch of that byte forwards wd into the fetched
//                          lane. Undefined: read-before-write, old byte.
// ---------------------------------------------------------------------------
module wide_read_burst_mem #(
    parameter int AW_WORD = 6,
    parameter int LANES   = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    wide_read_burst_mem_if.slave  bus
);
    localparam int LW    = $clog2(LANES);
    localparam int DEPTH = LANES << AW_WORD;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    logic [7:0]         mem [DEPTH];
    state_t             state;
    logic [AW_WORD-1:0] ptr;
    logic [AW_WORD-1:0] remain;
    logic [8*LANES-1:0] fetch_word;
    logic               fetch_en;

    // Memory array: no reset, writes accepted in every state.
    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // Gather all lanes of the word at ptr. The array is read before this
    // edge's write lands, so a colliding byte returns its old value unless
    // forwarding is compiled in.
    always_comb begin
        fetch_word = '0;
        for (int k = 0; k < LANES; k++) begin
            fetch_word[8*k +: 8] = mem[{ptr, LW'(k)}];
`ifdef WIDE_READ_BYPASS_EN
            if (bus.we && (bus.wa == {ptr, LW'(k)})) begin
                fetch_word[8*k +: 8] = bus.wd;
            end
`endif
        end
    end

    // A new word may be loaded when the output slot is empty or being
    // drained this edge.
    assign fetch_en = (state == FETCH) && (!bus.rd_valid || bus.rd_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            remain      <= '0;
            bus.rd_busy <= 1'b0;
            bus.rd_valid<= 1'b0;
            bus.rd_last <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_start) begin
                        ptr         <= bus.rd_addr;
                        remain      <= bus.rd_len;
                        bus.rd_busy <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_en) begin
                        bus.rd_data  <= fetch_word;
                        bus.rd_valid <= 1'b1;
                        bus.rd_last  <= (remain == '0);
                        ptr          <= ptr + 1'b1;  // wraps at the top word
                        if (remain == '0) begin
                            state <= DRAIN;
                        end else begin
                            remain <= remain - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Requests arriving here are dropped; rd_busy is still 1.
                    if (bus.rd_valid && bus.rd_ready) begin
                        bus.rd_valid <= 1'b0;
                        bus.rd_last  <= 1'b0;
                        bus.rd_busy  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_read_burst_mem.sv
module tb_wide_read_burst_mem;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wide_read_burst_mem_if #(.AW_WORD(6)) bus ();

    wide_read_burst_mem #(.AW_WORD(6), .LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        bus.we = 1'b1;
        bus.wa = a;
        bus.wd = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic start_burst(input logic [5:0] a, input logic [5:0] l);
        bus.rd_start = 1'b1;
        bus.rd_addr  = a;
        bus.rd_len   = l;
        tick();
        bus.rd_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.we       = 1'b0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.rd_start = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_len   = '0;
        bus.rd_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid, bus.rd_last} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000", {bus.rd_busy, bus.rd_valid, bus.rd_last});
        end
        checks++;
        if (bus.rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00000000", bus.rd_data);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) write_byte(8'(i), 8'(i));
        for (int i = 0; i < 4; i++) write_byte(8'(252 + i), 8'(8'hF0 + i));
    endtask

    task automatic test_basic();
        logic [31:0] e [4];
        e = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        bus.rd_ready = 1'b1;
        start_burst(6'd0, 6'd3);
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b10) begin
            failures++;
            $display("FAIL basic_start got=%b exp=10", {bus.rd_busy, bus.rd_valid});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, 1'b1, (i == 3), e[i]}) begin
                failures++;
                $display("FAIL basic_word%0d got=%b%b%b_%h exp=11%b_%h", i,
                         bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_data, (i == 3), e[i]);
            end
        end
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid, bus.rd_last} !== 3'b000) begin
            failures++;
            $display("FAIL basic_end got=%b exp=000", {bus.rd_busy, bus.rd_valid, bus.rd_last});
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e [2];
        e = '{32'hF3F2F1F0, 32'h03020100};
        start_burst(6'd63, 6'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, 1'b1, (i == 1), e[i]}) begin
                failures++;
                $display("FAIL wrap_word%0d got=%b%b%b_%h exp=11%b_%h", i,
                         bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_data, (i == 1), e[i]);
            end
        end
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL wrap_end got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e [4];
        e = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        start_burst(6'd0, 6'd3);
        tick();
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, e[0]}) begin
            failures++;
            $display("FAIL bp_first got=%b_%h exp=1_%h", bus.rd_valid, bus.rd_data, e[0]);
        end
        bus.rd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, 1'b0, e[0]}) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b%b_%h exp=10_%h", c,
                         bus.rd_valid, bus.rd_last, bus.rd_data, e[0]);
            end
        end
        bus.rd_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, (i == 3), e[i]}) begin
                failures++;
                $display("FAIL bp_word%0d got=%b%b_%h exp=1%b_%h", i,
                         bus.rd_valid, bus.rd_last, bus.rd_data, (i == 3), e[i]);
            end
        end
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL bp_end got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] e [4];
        e = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        start_burst(6'd0, 6'd3);
        tick();
        bus.rd_start = 1'b1;
        bus.rd_addr  = 6'd5;
        bus.rd_len   = 6'd0;
        for (int i = 1; i < 4; i++) begin
            tick();
            bus.rd_start = 1'b0;
            checks++;
            if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, (i == 3), e[i]}) begin
                failures++;
                $display("FAIL busy_word%0d got=%b%b_%h exp=1%b_%h", i,
                         bus.rd_valid, bus.rd_last, bus.rd_data, (i == 3), e[i]);
            end
        end
        // request on the edge that accepts the final word
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL busy_last_accept got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL busy_no_queue got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
    endtask

    task automatic test_collision();
        logic [7:0]  l1;
        logic [31:0] exp_w;
`ifdef WIDE_READ_BYPASS_EN
        l1 = 8'hAA;
`else
        l1 = 8'h09;
`endif
        exp_w = {8'h0B, 8'h0A, l1, 8'h08};
        start_burst(6'd0, 6'd3);
        tick();
        tick();
        checks++;
        if (bus.rd_data !== 32'h07060504) begin
            failures++;
            $display("FAIL coll_word1 got=%h exp=07060504", bus.rd_data);
        end
        bus.we = 1'b1;
        bus.wa = 8'd9;
        bus.wd = 8'hAA;
        tick();
        bus.we = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp_w}) begin
            failures++;
            $display("FAIL coll_word2 got=%b_%h exp=1_%h", bus.rd_valid, bus.rd_data, exp_w);
        end
        tick();
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL coll_end got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
    endtask

    task automatic test_reset_midburst();
        logic [31:0] e [4];
        e = '{32'h03020100, 32'h07060504, 32'h0B0AAA08, 32'h0F0E0D0C};
        start_burst(6'd0, 6'd3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_data} !== 35'h0) begin
            failures++;
            $display("FAIL rst_async got=%b%b%b_%h exp=000_00000000",
                     bus.rd_busy, bus.rd_valid, bus.rd_last, bus.rd_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_release got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
        start_burst(6'd0, 6'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({bus.rd_valid, bus.rd_last, bus.rd_data} !== {1'b1, (i == 3), e[i]}) begin
                failures++;
                $display("FAIL rst_word%0d got=%b%b_%h exp=1%b_%h", i,
                         bus.rd_valid, bus.rd_last, bus.rd_data, (i == 3), e[i]);
            end
        end
        tick();
        checks++;
        if ({bus.rd_busy, bus.rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_end got=%b exp=00", {bus.rd_busy, bus.rd_valid});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_busy_ignore();
        test_collision();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
